// File: rtl/sobel_feldman_stream_if.sv
// Pixel-column stream into the 3x3 edge filter and gradient-magnitude stream out of it.
// The source drives the master side; the filter uses the slave side.
interface sobel_feldman_stream_if #(
    parameter int unsigned Y_DEPTH = 8
);
    logic               i_valid;
    logic               i_sol;
    logic               i_eol;
    logic [Y_DEPTH-1:0] i_pixel_11_11;
    logic [Y_DEPTH-1:0] i_pixel_00_11;
    logic [Y_DEPTH-1:0] i_pixel_01_11;
    logic [1:0]         i_mode;
    logic               i_thresh_en;
    logic [Y_DEPTH-1:0] i_thresh;
    logic               o_ready;
    logic               o_valid;
    logic               o_sol;
    logic               o_eol;
    logic [Y_DEPTH-1:0] o_pixel;
    logic               o_edge;

    modport master (
        output i_valid, i_sol, i_eol, i_pixel_11_11, i_pixel_00_11, i_pixel_01_11,
        output i_mode, i_thresh_en, i_thresh,
        input  o_ready, o_valid, o_sol, o_eol, o_pixel, o_edge
    );

    modport slave (
        input  i_valid, i_sol, i_eol, i_pixel_11_11, i_pixel_00_11, i_pixel_01_11,
        input  i_mode, i_thresh_en, i_thresh,
        output o_ready, o_valid, o_sol, o_eol, o_pixel, o_edge
    );
endinterface

// File: rtl/sobel_feldman_stream.sv
// Streaming 3x3 Sobel/Prewitt/Scharr edge filter: builds the window from 3-row pixel columns,
// replicates edge columns at line boundaries and emits one gradient magnitude per column.
module sobel_feldman_stream #(
    parameter int unsigned Y_DEPTH  = 8,
    parameter int unsigned MAG_MODE = 0,
    parameter int unsigned NORM_EN  = 0
) (
    input logic                   i_pclk,
    input logic                   i_arstn,
    sobel_feldman_stream_if.slave bus
);
    localparam int unsigned GW = Y_DEPTH + 5;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;
    // One column, index 0 = top row, 2 = bottom row.
    typedef logic [2:0][Y_DEPTH-1:0] col_t;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [1:0]           mode_q, mode_d;
    col_t [2:0]           win_q, win_d;
    logic                 sol_pend_q, sol_pend_d;
    logic                 win_vld_q, win_vld_d, win_sol_q, win_sol_d, win_eol_q, win_eol_d;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                 s1_vld_q, s1_sol_q, s1_eol_q;
    logic [1:0]           s1_mode_q;
    logic [Y_DEPTH-1:0]   s2_pix_q, s2_pix_d;
    logic                 s2_vld_q, s2_sol_q, s2_eol_q;
    logic                 o_valid_q, o_valid_d, o_sol_q, o_sol_d, o_eol_q, o_eol_d;
    logic [Y_DEPTH-1:0]   o_pixel_q, o_pixel_d;
    logic                 o_edge_q, o_edge_d;

    col_t                 col_in;
    logic                 take, edge_c;
    logic signed [GW-1:0] wc, wm;
    logic [GW-1:0]        ax, ay, mag, mag_n;

    function automatic logic signed [GW-1:0] px(input logic [Y_DEPTH-1:0] v);
        return $signed({5'b0, v});
    endfunction

    always_comb begin
        col_in = {bus.i_pixel_01_11, bus.i_pixel_00_11, bus.i_pixel_11_11};
        // Non-sol beats arriving while idle are handshaken but discarded.
        take   = bus.i_valid & ready_q & (bus.i_sol | (state_q != StIdle));

        state_d    = state_q;
        mode_d     = mode_q;
        win_d      = win_q;
        sol_pend_d = sol_pend_q;
        win_vld_d  = 1'b0;
        win_sol_d  = 1'b0;
        win_eol_d  = 1'b0;

        unique case (state_q)
            StIdle:  if (take) state_d = bus.i_eol ? StFlush : StRun;
            StRun:   if (take && bus.i_eol) state_d = StFlush;
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (take) begin
            win_d[0] = win_q[1];
            win_d[1] = bus.i_sol ? col_in : win_q[2];
            win_d[2] = col_in;
            if (bus.i_sol) begin
                mode_d     = bus.i_mode;
                sol_pend_d = 1'b1;
            end else begin
                win_vld_d  = 1'b1;
                win_sol_d  = sol_pend_q;
                sol_pend_d = 1'b0;
            end
        end else if (state_q == StFlush) begin
            // Right edge: the last column stays in W2 and becomes its own right neighbour.
            win_d[0]   = win_q[1];
            win_d[1]   = win_q[2];
            win_vld_d  = 1'b1;
            win_sol_d  = sol_pend_q;
            win_eol_d  = 1'b1;
            sol_pend_d = 1'b0;
        end
        ready_d = (state_d != StFlush);

        unique case (mode_q)
            2'd1:    begin wc = GW'(1); wm = GW'(1);  end
            2'd2:    begin wc = GW'(3); wm = GW'(10); end
            default: begin wc = GW'(1); wm = GW'(2);  end
        endcase
        gx_d = wc * (px(win_q[2][0]) - px(win_q[0][0]))
             + wm * (px(win_q[2][1]) - px(win_q[0][1]))
             + wc * (px(win_q[2][2]) - px(win_q[0][2]));
        gy_d = wc * (px(win_q[0][2]) - px(win_q[0][0]))
             + wm * (px(win_q[1][2]) - px(win_q[1][0]))
             + wc * (px(win_q[2][2]) - px(win_q[2][0]));

        ax  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag = (ax > ay) ? ax : ay;
        if (MAG_MODE == 0) mag = ax + ay;
        mag_n = mag;
        if (NORM_EN != 0) mag_n = (s1_mode_q == 2'd2) ? (mag >> 4) : (mag >> 2);
        s2_pix_d = (|mag_n[GW-1:Y_DEPTH]) ? '1 : mag_n[Y_DEPTH-1:0];

        edge_c    = (s2_pix_q >= bus.i_thresh);
        o_valid_d = s2_vld_q;
        o_sol_d   = s2_vld_q & s2_sol_q;
        o_eol_d   = s2_vld_q & s2_eol_q;
        o_edge_d  = s2_vld_q & edge_c;
        o_pixel_d = '0;
        if (s2_vld_q) o_pixel_d = bus.i_thresh_en ? {Y_DEPTH{edge_c}} : s2_pix_q;
    end

    always_ff @(posedge i_pclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            mode_q     <= '0;
            win_q      <= '0;
            sol_pend_q <= 1'b0;
            win_vld_q  <= 1'b0;
            win_sol_q  <= 1'b0;
            win_eol_q  <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            s1_vld_q   <= 1'b0;
            s1_sol_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_mode_q  <= '0;
            s2_pix_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_sol_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_sol_q    <= 1'b0;
            o_eol_q    <= 1'b0;
            o_pixel_q  <= '0;
            o_edge_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            mode_q     <= mode_d;
            win_q      <= win_d;
            sol_pend_q <= sol_pend_d;
            win_vld_q  <= win_vld_d;
            win_sol_q  <= win_sol_d;
            win_eol_q  <= win_eol_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            s1_vld_q   <= win_vld_q;
            s1_sol_q   <= win_sol_q;
            s1_eol_q   <= win_eol_q;
            s1_mode_q  <= mode_q;
            s2_pix_q   <= s2_pix_d;
            s2_vld_q   <= s1_vld_q;
            s2_sol_q   <= s1_sol_q;
            s2_eol_q   <= s1_eol_q;
            o_valid_q  <= o_valid_d;
            o_sol_q    <= o_sol_d;
            o_eol_q    <= o_eol_d;
            o_pixel_q  <= o_pixel_d;
            o_edge_q   <= o_edge_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sol   = o_sol_q;
    assign bus.o_eol   = o_eol_q;
    assign bus.o_pixel = o_pixel_q;
    assign bus.o_edge  = o_edge_q;
endmodule

// File: tb/tb_sobel_feldman_stream.sv
// Bench for sobel_feldman_stream: two configurations (sum/raw and max/normalised) share one
// input stream; outputs are checked against a column-list model of the filter.
module tb_sobel_feldman_stream;
    localparam int unsigned YD = 8;

    typedef struct {int t; int m; int b;} col_s;
    typedef struct {int pix; bit sol; bit eol; bit edg;} exp_s;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_feldman_stream_if #(.Y_DEPTH(YD)) bus0 ();
    sobel_feldman_stream_if #(.Y_DEPTH(YD)) bus1 ();

    assign bus1.i_valid       = bus0.i_valid;
    assign bus1.i_sol         = bus0.i_sol;
    assign bus1.i_eol         = bus0.i_eol;
    assign bus1.i_pixel_11_11 = bus0.i_pixel_11_11;
    assign bus1.i_pixel_00_11 = bus0.i_pixel_00_11;
    assign bus1.i_pixel_01_11 = bus0.i_pixel_01_11;
    assign bus1.i_mode        = bus0.i_mode;
    assign bus1.i_thresh_en   = bus0.i_thresh_en;
    assign bus1.i_thresh      = bus0.i_thresh;

    sobel_feldman_stream #(.Y_DEPTH(YD), .MAG_MODE(0), .NORM_EN(0)) dut0 (
        .i_pclk(clk), .i_arstn(rst_n), .bus(bus0)
    );
    sobel_feldman_stream #(.Y_DEPTH(YD), .MAG_MODE(1), .NORM_EN(1)) dut1 (
        .i_pclk(clk), .i_arstn(rst_n), .bus(bus1)
    );

    int   tests = 0;
    int   fails = 0;
    int   nval0 = 0;
    exp_s exp_q0[$];
    exp_s exp_q1[$];
    int   obs0[$];
    col_s line[$];
    bit   in_line = 0;
    int   line_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int grad(col_s l, col_s c, col_s r, int mode, bit use_max, bit norm);
        int wc, wm, gx, gy, ax, ay, mag;
        wc  = (mode == 2) ? 3 : 1;
        wm  = (mode == 2) ? 10 : ((mode == 1) ? 1 : 2);
        gx  = wc * (r.t - l.t) + wm * (r.m - l.m) + wc * (r.b - l.b);
        gy  = wc * (l.b - l.t) + wm * (c.b - c.t) + wc * (r.b - r.t);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = use_max ? ((ax > ay) ? ax : ay) : ax + ay;
        if (norm) mag = mag / ((mode == 2) ? 16 : 4);
        if (mag > 255) mag = 255;
        return mag;
    endfunction

    // Output for column k of the current line; the last column is its own right neighbour.
    task automatic emit(input int k, input bit last);
        col_s l, c, r;
        exp_s e;
        int   pre;
        l = line[(k > 0) ? k - 1 : 0];
        c = line[k];
        r = last ? line[k] : line[k + 1];
        for (int d = 0; d < 2; d++) begin
            pre   = grad(l, c, r, line_mode, d == 1, d == 1);
            e.sol = (k == 0);
            e.eol = last;
            e.edg = (pre >= int'(bus0.i_thresh));
            e.pix = bus0.i_thresh_en ? (e.edg ? 255 : 0) : pre;
            if (d == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    endtask

    task automatic model_accept(input bit sol, input bit eol, input col_s c, input int mode);
        if (!in_line && !sol) return;
        if (sol) begin
            line.delete();
            line.push_back(c);
            line_mode = mode;
            in_line   = 1;
        end else begin
            line.push_back(c);
            emit(line.size() - 2, 0);
        end
        if (eol) begin
            emit(line.size() - 1, 1);
            in_line = 0;
        end
    endtask

    task automatic send(input bit sol, input bit eol, input int t, input int m, input int b,
                        input int mode);
        int   tries = 0;
        col_s c;
        @(negedge clk);
        bus0.i_valid       = 1'b1;
        bus0.i_sol         = sol;
        bus0.i_eol         = eol;
        bus0.i_pixel_11_11 = YD'(t);
        bus0.i_pixel_00_11 = YD'(m);
        bus0.i_pixel_01_11 = YD'(b);
        bus0.i_mode        = 2'(mode);
        while (!bus0.o_ready && tries < 4) begin
            @(negedge clk);
            tries++;
        end
        chk("ready_bound", bus0.o_ready, 1);
        @(posedge clk);
        c.t = t; c.m = m; c.b = b;
        model_accept(sol, eol, c, mode);
        #1 bus0.i_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid0"}, bus0.o_valid, 0);
        chk({tag, "_sol0"}, bus0.o_sol, 0);
        chk({tag, "_eol0"}, bus0.o_eol, 0);
        chk({tag, "_pixel0"}, bus0.o_pixel, 0);
        chk({tag, "_edge0"}, bus0.o_edge, 0);
        chk({tag, "_ready0"}, bus0.o_ready, 1);
        chk({tag, "_valid1"}, bus1.o_valid, 0);
        chk({tag, "_pixel1"}, bus1.o_pixel, 0);
        chk({tag, "_ready1"}, bus1.o_ready, 1);
    endtask

    always @(negedge clk) begin
        exp_s e;
        if (bus0.o_valid === 1'b1) begin
            nval0++;
            obs0.push_back(int'(bus0.o_pixel));
            chk("out0_expected", exp_q0.size() > 0, 1);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                chk("out0_pixel", bus0.o_pixel, e.pix);
                chk("out0_sol", bus0.o_sol, e.sol);
                chk("out0_eol", bus0.o_eol, e.eol);
                chk("out0_edge", bus0.o_edge, e.edg);
            end
        end
        if (bus1.o_valid === 1'b1) begin
            chk("out1_expected", exp_q1.size() > 0, 1);
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                chk("out1_pixel", bus1.o_pixel, e.pix);
                chk("out1_sol", bus1.o_sol, e.sol);
                chk("out1_eol", bus1.o_eol, e.eol);
                chk("out1_edge", bus1.o_edge, e.edg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, lat, len, p;
        int t3exp[3];
        int t2exp[4];
        bit ab, sol_b, eol_b;
        t3exp = '{149, 111, 149};
        t2exp = '{0, 255, 255, 0};
        bus0.i_valid = 0; bus0.i_sol = 0; bus0.i_eol = 0;
        bus0.i_pixel_11_11 = 0; bus0.i_pixel_00_11 = 0; bus0.i_pixel_01_11 = 0;
        bus0.i_mode = 0; bus0.i_thresh_en = 0; bus0.i_thresh = 0;

        #23;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        drain(2);

        // T1: flat line gives zero gradient, one bubble after eol.
        base = nval0;
        for (int i = 0; i < 5; i++) send(i == 0, i == 4, 128, 128, 128, 0);
        chk("t1_ready_low", bus0.o_ready, 0);
        @(posedge clk);
        #1 chk("t1_ready_back", bus0.o_ready, 1);
        drain(8);
        chk("t1_count", nval0 - base, 5);

        // T2: vertical step edge.
        obs0.delete();
        for (int i = 0; i < 4; i++) begin
            p = (i < 2) ? 0 : 255;
            send(i == 0, i == 3, p, p, p, 0);
        end
        drain(8);
        chk("t2_count", obs0.size(), 4);
        for (int i = 0; i < 4; i++) if (i < obs0.size()) chk("t2_pixel", obs0[i], t2exp[i]);

        // T3: single-column line in each kernel, latency 4.
        for (int m = 0; m < 3; m++) begin
            send(1, 1, 225, 0, 76, m);
            lat = 0;
            while (bus0.o_valid !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            chk("t3_latency", lat, 4);
            chk("t3_pixel_norm", bus1.o_pixel, t3exp[m]);
            chk("t3_pixel_sat", bus0.o_pixel, 255);
            chk("t3_sol_eol", {bus1.o_sol, bus1.o_eol}, 3);
            drain(6);
        end

        // T4: threshold straddling the normalised Sobel result of 149.
        for (int i = 0; i < 2; i++) begin
            bus0.i_thresh_en = 1'b1;
            bus0.i_thresh    = (i == 0) ? 8'd150 : 8'd149;
            send(1, 1, 225, 0, 76, 0);
            lat = 0;
            while (bus1.o_valid !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            chk("t4_pixel", bus1.o_pixel, (i == 0) ? 0 : 255);
            chk("t4_edge", bus1.o_edge, (i == 0) ? 0 : 1);
            drain(6);
        end
        bus0.i_thresh_en = 1'b0;
        bus0.i_thresh    = 8'd100;

        // T5: reset in the middle of a line, then orphan beats.
        send(1, 0, 10, 200, 30, 2);
        send(0, 0, 90, 20, 250, 2);
        send(0, 0, 5, 60, 180, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t5");
        exp_q0.delete();
        exp_q1.delete();
        in_line = 0;
        @(negedge clk) rst_n = 1'b1;
        base = nval0;
        for (int i = 0; i < 3; i++) send(0, i == 2, 50 * i, 255, 0, 0);
        drain(8);
        chk("t5_no_valid", nval0 - base, 0);

        // T6: abandoned 3-beat line followed by a 2-beat line.
        base = nval0;
        send(1, 0, 0, 0, 0, 0);
        send(0, 0, 255, 128, 0, 1);
        send(0, 0, 40, 40, 200, 2);
        send(1, 0, 17, 99, 3, 2);
        send(0, 1, 200, 10, 120, 0);
        drain(8);
        chk("t6_count", nval0 - base, 4);

        // Random lines, gaps, ignored mid-line mode changes and stray beats while idle.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                drain(8);
                bus0.i_thresh_en = 1'($urandom_range(0, 1));
                bus0.i_thresh    = YD'($urandom_range(0, 255));
            end
            if (!in_line && $urandom_range(0, 7) == 0)
                send(0, 1'($urandom_range(0, 1)), 255, 0, 255, 0);
            len = $urandom_range(1, 8);
            ab  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                sol_b = (i == 0);
                eol_b = (i == len - 1) && !ab;
                send(sol_b, eol_b, $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 3));
            end
        end
        send(1, 1, 1, 2, 3, 0);
        drain(10);
        chk("final_queue0", exp_q0.size(), 0);
        chk("final_queue1", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
